// File: rtl/ht_free_ptr_pool_pkg.sv
// Shared hash-table types: free-pointer width/type and the pool's INIT/READY state encoding.
package hash_table;

  localparam int TABLE_ADDR_WIDTH = 10;
  localparam int HEAD_PTR_WIDTH   = TABLE_ADDR_WIDTH;

  typedef logic [HEAD_PTR_WIDTH-1:0] free_ptr_t;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } free_ptr_pool_state_t;

endpackage

// File: rtl/ht_free_ptr_pool.sv
// Free-pointer pool: circular FIFO self-initialised with 0..DEPTH-1, show-ahead alloc, free push-back.
// Optional double-free detection via in-pool bitmap when HT_FREE_PTR_DBL_FREE_CHECK_EN is defined.
module ht_free_ptr_pool
  import hash_table::*;
#(
  parameter int ADDR_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  srst_i,
  output logic [ADDR_WIDTH-1:0] alloc_ptr_o,
  output logic                  alloc_val_o,
  input  logic                  alloc_rd_i,
  input  logic [ADDR_WIDTH-1:0] free_ptr_i,
  input  logic                  free_val_i,
  output logic                  free_ready_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  init_done_o,
  output logic                  dbl_free_err_o
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  free_ptr_pool_state_t  r_state;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_wr_idx;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_init_done;
  logic                  w_not_empty;
  logic                  w_not_full;
  logic                  w_pop;
  logic                  w_free_acc;
  logic                  w_dup;
  logic                  w_push;
  logic                  w_init_wr;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_wdata;

  assign w_init_done = (r_state == READY);
  assign w_not_empty = (r_count != '0);
  assign w_not_full  = (r_count != DEPTH_CNT);

  // srst_i masks both handshakes so a restart never records a pop or push.
  assign w_pop      = w_init_done & alloc_rd_i & w_not_empty & ~srst_i;
  assign w_free_acc = free_val_i & free_ready_o & ~srst_i;
  assign w_push     = w_free_acc & ~w_dup;
  assign w_init_wr  = (r_state == INIT) & ~srst_i;

  assign w_mem_we    = w_init_wr | w_push;
  assign w_mem_wdata = w_init_wr ? r_wr_idx : free_ptr_i;

  always_ff @(posedge clk_i) begin
    if (w_mem_we) r_mem[r_wr_idx] <= w_mem_wdata;
  end

`ifdef HT_FREE_PTR_DBL_FREE_CHECK_EN
  logic [DEPTH-1:0] r_in_pool;
  logic             r_dbl_err;

  assign w_dup = r_in_pool[free_ptr_i];

  // Pop clears before push sets, so a pointer returned in the cycle it leaves is still a duplicate.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_in_pool <= '0;
      r_dbl_err <= 1'b0;
    end else if (srst_i) begin
      r_in_pool <= '0;
      r_dbl_err <= 1'b0;
    end else begin
      r_dbl_err <= w_free_acc & w_dup;
      if (r_state == INIT) begin
        r_in_pool[r_wr_idx] <= 1'b1;
      end else begin
        if (w_pop)  r_in_pool[r_mem[r_rd_idx]] <= 1'b0;
        if (w_push) r_in_pool[free_ptr_i]      <= 1'b1;
      end
    end
  end

  assign dbl_free_err_o = r_dbl_err;
`else
  assign w_dup          = 1'b0;
  assign dbl_free_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= INIT;
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_count  <= '0;
    end else if (srst_i) begin
      r_state  <= INIT;
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_wr_idx <= r_wr_idx + 1'b1;
          r_count  <= r_count + 1'b1;
          if (r_count == DEPTH_CNT - 1'b1) r_state <= READY;
        end
        default: begin
          if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
          if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
          if (w_push && !w_pop)      r_count <= r_count + 1'b1;
          else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
      endcase
    end
  end

  assign alloc_val_o  = w_init_done & w_not_empty;
  assign alloc_ptr_o  = w_init_done ? r_mem[r_rd_idx] : '0;
  assign free_ready_o = w_init_done & w_not_full;
  assign count_o      = r_count;
  assign empty_o      = w_init_done & ~w_not_empty;
  assign full_o       = ~w_not_full;
  assign init_done_o  = w_init_done;

endmodule

// File: tb/tb_ht_free_ptr_pool.sv
// Bench for ht_free_ptr_pool (ADDR_WIDTH=3): vector table, hand corner sequences, random vs queue model.
module tb_ht_free_ptr_pool;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          srst_i;
  logic [AW-1:0] alloc_ptr_o;
  logic          alloc_val_o;
  logic          alloc_rd_i;
  logic [AW-1:0] free_ptr_i;
  logic          free_val_i;
  logic          free_ready_o;
  logic [AW:0]   count_o;
  logic          empty_o;
  logic          full_o;
  logic          init_done_o;
  logic          dbl_free_err_o;

  ht_free_ptr_pool #(.ADDR_WIDTH(AW)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .srst_i         (srst_i),
    .alloc_ptr_o    (alloc_ptr_o),
    .alloc_val_o    (alloc_val_o),
    .alloc_rd_i     (alloc_rd_i),
    .free_ptr_i     (free_ptr_i),
    .free_val_i     (free_val_i),
    .free_ready_o   (free_ready_o),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .init_done_o    (init_done_o),
    .dbl_free_err_o (dbl_free_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pool contents as an ordered queue of pointer values.
  int q[$];
  bit m_ready;
  int m_init;
  bit m_dbl;

`ifdef HT_FREE_PTR_DBL_FREE_CHECK_EN
  localparam bit DBL_CHK = 1'b1;
`else
  localparam bit DBL_CHK = 1'b0;
`endif

  typedef struct {
    bit rd;
    bit fv;
    int fp;
    bit exp_val;
    int exp_ptr;
    int exp_cnt;
    bit exp_empty;
    bit exp_full;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_pool(input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_ready = 1'b0;
    m_init  = 0;
    m_dbl   = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit rd, input bit fv, input int fp);
    bit pop, acc, dup;
    if (s) begin
      model_reset();
    end else if (!m_ready) begin
      m_init++;
      m_dbl = 1'b0;
      if (m_init == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) q.push_back(i);
      end
    end else begin
      pop = rd && (q.size() != 0);
      acc = fv && (q.size() != DEPTH);
      dup = DBL_CHK && acc && in_pool(fp);
      if (pop) void'(q.pop_front());
      if (acc && !dup) q.push_back(fp);
      m_dbl = dup;
    end
  endfunction

  task automatic check_model();
    int cnt;
    cnt = m_ready ? q.size() : m_init;
    chk("count", count_o, cnt);
    chk("init_done", init_done_o, m_ready);
    chk("alloc_val", alloc_val_o, m_ready && cnt != 0);
    chk("free_ready", free_ready_o, m_ready && cnt != DEPTH);
    chk("empty", empty_o, m_ready && cnt == 0);
    chk("full", full_o, cnt == DEPTH);
    chk("dbl_free_err", dbl_free_err_o, m_dbl);
    if (!m_ready) chk("alloc_ptr_init", alloc_ptr_o, 0);
    else if (cnt != 0) chk("alloc_ptr", alloc_ptr_o, q[0]);
  endtask

  task automatic cycle(input bit s, input bit rd, input bit fv, input int fp);
    logic [31:0] fpv;
    fpv        = fp;
    srst_i     = s;
    alloc_rd_i = rd;
    free_val_i = fv;
    free_ptr_i = fpv[AW-1:0];
    model_step(s, rd, fv, fp);
    @(posedge clk_i);
    #1;
    srst_i     = 1'b0;
    alloc_rd_i = 1'b0;
    free_val_i = 1'b0;
    check_model();
  endtask

  function automatic void addv(input bit rd, input bit fv, input int fp, input bit ev,
                               input int ep, input int ec, input bit ee, input bit ef);
    vec_t v;
    v.rd = rd; v.fv = fv; v.fp = fp; v.exp_val = ev;
    v.exp_ptr = ep; v.exp_cnt = ec; v.exp_empty = ee; v.exp_full = ef;
    vt.push_back(v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_alloc_val"}, alloc_val_o, 0);
    chk({tag, "_alloc_ptr"}, alloc_ptr_o, 0);
    chk({tag, "_free_ready"}, free_ready_o, 0);
    chk({tag, "_init_done"}, init_done_o, 0);
    chk({tag, "_empty"}, empty_o, 0);
    chk({tag, "_full"}, full_o, 0);
    chk({tag, "_dbl"}, dbl_free_err_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fixed vectors from a freshly initialised full pool: {rd, fv, fp, val, ptr, count, empty, full}
    for (int k = 1; k <= 8; k++) addv(1, 0, 0, k < 8, k, 8 - k, k == 8, k == 0);
    addv(1, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 5, 1, 5, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 1, 0);
    addv(0, 1, 0, 1, 0, 1, 0, 0);
    addv(0, 1, 1, 1, 0, 2, 0, 0);
    addv(0, 1, 2, 1, 0, 3, 0, 0);
    addv(0, 1, 3, 1, 0, 4, 0, 0);
    addv(1, 1, 4, 1, 1, 4, 0, 0);
    addv(1, 1, 5, 1, 2, 4, 0, 0);
    addv(1, 1, 6, 1, 3, 4, 0, 0);
    addv(1, 1, 7, 1, 4, 4, 0, 0);
    addv(1, 1, 0, 1, 5, 4, 0, 0);
    addv(1, 1, 1, 1, 6, 4, 0, 0);
    addv(1, 0, 0, 1, 7, 3, 0, 0);
    addv(1, 0, 0, 1, 0, 2, 0, 0);
    addv(1, 0, 0, 1, 1, 1, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 1, 0);

    rst_n_i = 1'b0; srst_i = 1'b0; alloc_rd_i = 1'b0; free_val_i = 1'b0; free_ptr_i = '0;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    check_reset_outputs("por");
    rst_n_i = 1'b1;

    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0);
    chk("init_done_after8", init_done_o, 1);
    chk("init_count8", count_o, 8);
    chk("init_full", full_o, 1);
    chk("init_ptr0", alloc_ptr_o, 0);

    foreach (vt[i]) begin
      alloc_rd_i = vt[i].rd;
      free_val_i = vt[i].fv;
      free_ptr_i = vt[i].fp[AW-1:0];
      model_step(0, vt[i].rd, vt[i].fv, vt[i].fp);
      @(posedge clk_i); #1;
      alloc_rd_i = 1'b0; free_val_i = 1'b0;
      chk($sformatf("vec%0d_val", i), alloc_val_o, vt[i].exp_val);
      if (vt[i].exp_val) chk($sformatf("vec%0d_ptr", i), alloc_ptr_o, vt[i].exp_ptr);
      chk($sformatf("vec%0d_count", i), count_o, vt[i].exp_cnt);
      chk($sformatf("vec%0d_empty", i), empty_o, vt[i].exp_empty);
      chk($sformatf("vec%0d_full", i), full_o, vt[i].exp_full);
    end

    // srst with a concurrent alloc: restart wins, nothing popped
    cycle(0, 0, 1, 3);
    cycle(1, 1, 0, 0);
    chk("srst_count0", count_o, 0);
    chk("srst_init_done0", init_done_o, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);

    // asynchronous reset in the middle of INIT
    #2;
    rst_n_i = 1'b0;
    #1;
    check_reset_outputs("async_mid_init");
    model_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) cycle(0, 0, 0, 0);
    chk("rerun_not_done_at7", init_done_o, 0);
    cycle(0, 0, 0, 0);
    chk("rerun_done", init_done_o, 1);
    chk("rerun_count8", count_o, 8);
    chk("rerun_ptr0", alloc_ptr_o, 0);

    // double free of pointer 2 after popping 0,1,2
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 2);
    chk("df_first_count", count_o, 6);
    cycle(0, 0, 1, 2);
`ifdef HT_FREE_PTR_DBL_FREE_CHECK_EN
    chk("df_pulse", dbl_free_err_o, 1);
    chk("df_dropped_count", count_o, 6);
    cycle(0, 0, 0, 0);
    chk("df_pulse_one_cycle", dbl_free_err_o, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    chk("df_final_count", count_o, 8);
    chk("df_final_full", full_o, 1);
`else
    chk("df_no_check_pushed", count_o, 7);
    chk("df_no_check_pulse", dbl_free_err_o, 0);
`endif

    cycle(1, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1),
            $urandom_range(0, 2) != 0, $urandom_range(0, DEPTH - 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
